// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder and program loader.
// Takes one field-level descriptor per handshake, packs it into a 32-bit
// RV32I word after checking the immediate range, and writes the words to
// consecutive instruction-memory addresses starting at BASE_ADDR.
module instr_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_format,
  input  logic [6:0]            in_op,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic                  imem_ready,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;

  state_t                state_q;
  logic                  in_ready_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  done_q;
  logic                  error_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  last_q;

  logic [31:0]           enc_d;
  logic                  legal_d;
  logic                  is_shift;
  logic                  fits_12;
  logic                  fits_b;
  logic                  fits_j;

  // Immediate range checks: the dropped upper bits must all equal the sign bit.
  assign is_shift = (in_op == 7'b0010011) && ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));
  assign fits_12  = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits_b   = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
  assign fits_j   = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];

  // Pack the descriptor into an RV32I word and decide whether it is legal.
  always_comb begin
    enc_d   = '0;
    legal_d = 1'b0;
    case (in_format)
      3'd0: begin
        enc_d   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
        legal_d = 1'b1;
      end
      3'd1: begin
        if (is_shift) begin
          enc_d   = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
          legal_d = (in_imm[31:5] == '0);
        end else begin
          enc_d   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
          legal_d = fits_12;
        end
      end
      3'd2: begin
        enc_d   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
        legal_d = fits_12;
      end
      3'd3: begin
        enc_d   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_op};
        legal_d = fits_b;
      end
      3'd4: begin
        enc_d   = {in_imm[31:12], in_rd, in_op};
        legal_d = 1'b1;
      end
      3'd5: begin
        enc_d   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
        legal_d = fits_j;
      end
      default: begin
        enc_d   = '0;
        legal_d = 1'b0;
      end
    endcase
  end

  // Load sequencer with registered outputs; start overrides every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      addr_q     <= BASE;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      last_q     <= 1'b0;
    end else if (start) begin
      state_q    <= S_RUN;
      in_ready_q <= 1'b1;
      imem_we_q  <= 1'b0;
      addr_q     <= BASE;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (legal_d) begin
              wdata_q   <= enc_d;
              last_q    <= in_last;
              imem_we_q <= 1'b1;
              state_q   <= S_WRITE;
            end else begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end
          end
        end
        S_WRITE: begin
          if (imem_ready) begin
            imem_we_q <= 1'b0;
            count_q   <= count_q + (ADDR_WIDTH + 1)'(1);
            // The address saturates at the top word instead of wrapping.
            if (addr_q != MAX_ADDR) begin
              addr_q <= addr_q + 1'b1;
            end
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (addr_q == MAX_ADDR) begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= S_RUN;
            end
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign error      = error_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed program loads plus randomized descriptors
// checked against an arithmetic model of the RV32I field packing.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, in_valid, in_last, imem_ready;
  logic [2:0]  in_format, in_funct3;
  logic [6:0]  in_op, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        rdy1, we1, done1, err1;
  logic [9:0]  addr1;
  logic [31:0] wd1;
  logic [10:0] cnt1;
  logic        rdy2, we2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  cnt2;

  instr_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_format(in_format), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .imem_ready(imem_ready),
    .done(done1), .error(err1), .count(cnt1)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy2),
    .in_format(in_format), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2), .imem_ready(imem_ready),
    .done(done2), .error(err2), .count(cnt2)
  );

  // Observed outputs of whichever instance the current test targets.
  bit          sel;
  logic        o_rdy, o_we, o_done, o_err;
  logic [9:0]  o_addr;
  logic [31:0] o_wd;
  logic [10:0] o_cnt;
  assign o_rdy  = sel ? rdy2 : rdy1;
  assign o_we   = sel ? we2 : we1;
  assign o_done = sel ? done2 : done1;
  assign o_err  = sel ? err2 : err1;
  assign o_addr = sel ? {8'd0, addr2} : addr1;
  assign o_wd   = sel ? wd2 : wd1;
  assign o_cnt  = sel ? {8'd0, cnt2} : cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_addr, exp_count, max_addr;

  // Reference: RV32I packing from integer immediates with plain arithmetic.
  function automatic void model_enc(input logic [2:0] fmt, input logic [6:0] op,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [31:0] imm,
                                    output bit legal, output logic [31:0] w);
    int          si;
    logic [31:0] base;
    si   = imm;
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (fmt)
      3'd0: begin
        legal = 1;
        w = base | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
      end
      3'd1: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          legal = (si >= 0) && (si <= 31);
          w = base | (32'(f7) << 25) | ((imm & 32'd31) << 20) | (32'(rd) << 7);
        end else begin
          legal = (si >= -2048) && (si <= 2047);
          w = base | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
        end
      end
      3'd2: begin
        legal = (si >= -2048) && (si <= 2047);
        w = base | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((imm & 32'd31) << 7);
      end
      3'd3: begin
        legal = (si >= -4096) && (si <= 4094) && (imm[0] == 1'b0);
        w = base | (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                 | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'd1) << 7);
      end
      3'd4: begin
        legal = 1;
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      3'd5: begin
        legal = (si >= -1048576) && (si <= 1048574) && (imm[0] == 1'b0);
        w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'hFF) << 12)
          | (32'(rd) << 7) | 32'(op);
      end
      default: begin
        legal = 0;
        w = '0;
      end
    endcase
  endfunction

  task automatic set_desc(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input bit last);
    in_format = fmt; in_op = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  // Called just after a negedge; returns after the accepting posedge.
  task automatic handshake(output bit ok);
    int n = 0;
    in_valid = 1'b1;
    while (o_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_rdy !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL handshake_timeout: in_ready=%b required 1", o_rdy);
      in_valid = 1'b0;
      ok = 0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    ok = 1;
  endtask

  // One descriptor end to end; 'ended' is set when the load stopped (error or done).
  task automatic do_instr(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm, input bit last,
                          input int stall, output logic [31:0] seen, output bit ended);
    bit          legal, ok, ovf, rdy_exp;
    logic [31:0] w;
    model_enc(fmt, op, f3, f7, rd, rs1, rs2, imm, legal, w);
    seen  = 'x;
    ended = 1;
    @(negedge clk);
    set_desc(fmt, op, f3, f7, rd, rs1, rs2, imm, last);
    imem_ready = (stall == 0);
    handshake(ok);
    if (!ok) return;
    if (!legal) begin
      @(negedge clk);
      n_tests++;
      if (o_err !== 1'b1 || o_we !== 1'b0 || o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_reject: error=%b we=%b rdy=%b required 1 0 0", o_err, o_we, o_rdy);
      end
      $display("[TB] txn fmt=%0d imm=%0d illegal", fmt, $signed(imm));
      return;
    end
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      n_tests++;
      if (o_we !== 1'b1 || o_addr !== 10'(exp_addr) || o_wd !== w || o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL write_hold[%0d]: we=%b addr=%0d data=%08h rdy=%b required 1 %0d %08h 0",
                 k, o_we, o_addr, o_wd, o_rdy, exp_addr, w);
      end
      if (k == stall) imem_ready = 1'b1;
    end
    seen = o_wd;
    @(negedge clk);
    exp_count++;
    ovf = (exp_addr == max_addr) && !last;
    if (exp_addr != max_addr) exp_addr++;
    rdy_exp = !last && !ovf;
    n_tests++;
    if (o_we !== 1'b0 || o_cnt !== 11'(exp_count) || o_addr !== 10'(exp_addr) ||
        o_done !== last || o_err !== ovf || o_rdy !== rdy_exp) begin
      n_fail++;
      $display("FAIL commit: we=%b cnt=%0d addr=%0d done=%b err=%b rdy=%b required 0 %0d %0d %b %b %b",
               o_we, o_cnt, o_addr, o_done, o_err, o_rdy, exp_count, exp_addr, last, ovf, rdy_exp);
    end
    ended = last || ovf;
    $display("[TB] txn fmt=%0d imm=%0d data=%08h count=%0d", fmt, $signed(imm), w, exp_count);
  endtask

  task automatic test_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_addr  = 0;
    exp_count = 0;
    @(negedge clk);
    n_tests++;
    if (o_rdy !== 1'b1 || o_we !== 1'b0 || o_addr !== 10'd0 || o_cnt !== 11'd0 ||
        o_done !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start: rdy=%b we=%b addr=%0d cnt=%0d done=%b err=%b required 1 0 0 0 0 0",
               o_rdy, o_we, o_addr, o_cnt, o_done, o_err);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_tests++;
    if (rdy1 !== 1'b0 || we1 !== 1'b0 || addr1 !== 10'd0 || wd1 !== 32'd0 ||
        done1 !== 1'b0 || err1 !== 1'b0 || cnt1 !== 11'd0 || we2 !== 1'b0 || rdy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b we=%b addr=%0d wdata=%08h done=%b err=%b cnt=%0d required all zero",
               name, rdy1, we1, addr1, wd1, done1, err1, cnt1);
    end
  endtask

  task automatic test_reset;
    #1 check_reset_vals("reset_async");
    @(negedge clk);
    check_reset_vals("reset_clocked");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_addi;
    logic [31:0] s; bit e;
    test_start;
    do_instr(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 0, s, e);
    n_tests++;
    if (s !== 32'h00500093) begin
      n_fail++; $display("FAIL addi_word: got %08h required 00500093", s);
    end
  endtask

  task automatic test_program;
    logic [31:0] s; bit e;
    test_start;
    do_instr(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 0, s, e);
    n_tests++;
    if (s !== 32'h402081B3) begin
      n_fail++; $display("FAIL sub_word: got %08h required 402081b3", s);
    end
    do_instr(3'd1, 7'h13, 3'd5, 7'h20, 5'd5, 5'd5, 5'd0, 32'd3, 1'b1, 0, s, e);
    n_tests++;
    if (s !== 32'h4032D293 || o_done !== 1'b1 || o_cnt !== 11'd2 || o_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL srai_done: word=%08h done=%b cnt=%0d rdy=%b required 4032d293 1 2 0",
               s, o_done, o_cnt, o_rdy);
    end
  endtask

  task automatic test_branch_jump;
    logic [31:0] s; bit e;
    test_start;
    do_instr(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0, 0, s, e);
    n_tests++;
    if (s !== 32'hFE208CE3) begin
      n_fail++; $display("FAIL beq_word: got %08h required fe208ce3", s);
    end
    do_instr(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 0, s, e);
    n_tests++;
    if (s !== 32'h001000EF) begin
      n_fail++; $display("FAIL jal_word: got %08h required 001000ef", s);
    end
  endtask

  task automatic test_stall;
    logic [31:0] s; bit e;
    test_start;
    do_instr(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd4, 5'd9, -32'sd2048, 1'b0, 3, s, e);
    do_instr(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hDEADBFFF, 1'b0, 2, s, e);
  endtask

  task automatic test_error;
    logic [31:0] s; bit e;
    test_start;
    do_instr(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 0, s, e);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (o_err !== 1'b1 || o_we !== 1'b0 || o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL err_hold[%0d]: err=%b we=%b rdy=%b required 1 0 0", k, o_err, o_we, o_rdy);
      end
    end
    test_start;
  endtask

  task automatic test_drop_pending;
    bit ok;
    test_start;
    @(negedge clk);
    set_desc(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'd1, 1'b0);
    imem_ready = 1'b0;
    handshake(ok);
    test_start;
    imem_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_we !== 1'b0 || o_cnt !== 11'd0) begin
      n_fail++; $display("FAIL drop_pending: we=%b cnt=%0d required 0 0", o_we, o_cnt);
    end
  endtask

  task automatic test_random(input int n);
    int bnd[16] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                    -4098, -1048576, 1048574, 1048576, 0, 31, 32, -1};
    logic [2:0]  fmt, f3;
    logic [6:0]  op;
    logic [31:0] imm, s;
    bit          last, e;
    test_start;
    for (int i = 0; i < n; i++) begin
      fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      op  = 7'($urandom);
      f3  = 3'($urandom);
      if (fmt == 3'd1 && $urandom_range(0, 1) == 1) begin
        op = 7'h13;
        f3 = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd1;
      end
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        2: imm = bnd[$urandom_range(0, 15)];
        default: imm = 32'($urandom_range(0, 40));
      endcase
      last = ($urandom_range(0, 9) == 0);
      do_instr(fmt, op, f3, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               imm, last, $urandom_range(0, 2), s, e);
      if (e) test_start;
    end
  endtask

  task automatic test_overflow;
    logic [31:0] s; bit e;
    sel = 1'b1;
    max_addr = 3;
    test_start;
    for (int i = 0; i < 4; i++) begin
      do_instr(3'd1, 7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0, 0, s, e);
    end
    @(negedge clk);
    set_desc(3'd1, 7'h13, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (o_we !== 1'b0 || o_err !== 1'b1 || o_cnt !== 11'd4 || o_addr !== 10'd3 || o_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL overflow_hold[%0d]: we=%b err=%b cnt=%0d addr=%0d rdy=%b required 0 1 4 3 0",
                 k, o_we, o_err, o_cnt, o_addr, o_rdy);
      end
    end
    in_valid = 1'b0;
    sel = 1'b0;
    max_addr = 1023;
    test_start;
  endtask

  task automatic test_async_reset;
    bit ok;
    test_start;
    @(negedge clk);
    set_desc(3'd0, 7'h33, 3'd7, 7'd0, 5'd8, 5'd6, 5'd4, 32'd0, 1'b0);
    imem_ready = 1'b0;
    handshake(ok);
    @(negedge clk);
    n_tests++;
    if (o_we !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_write: we=%b required 1", o_we);
    end
    #2 reset = 1'b1;
    #1 check_reset_vals("reset_mid_write");
    @(negedge clk);
    reset = 1'b0;
    imem_ready = 1'b1;
    test_start;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b1; sel = 1'b0;
    max_addr = 1023; exp_addr = 0; exp_count = 0;
    set_desc(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    test_reset;
    test_addi;
    test_program;
    test_branch_jump;
    test_stall;
    test_error;
    test_drop_pending;
    test_random(60);
    test_overflow;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
